// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS control sequencer.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    CLS_R, CLS_LW, CLS_SW, CLS_BEQ, CLS_J, CLS_ADDI, CLS_ORI, CLS_ILL
  } cls_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100
  } alu_e;

  // Encodings match the bit index of each phase in the one-hot phase bus.
  typedef enum logic [2:0] {
    PH_IF = 3'd0, PH_ID = 3'd1, PH_EX = 3'd2, PH_MEM = 3'd3, PH_WB = 3'd4, PH_NONE = 3'd5
  } ph_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct decoder producing instruction class and ALU control.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output cls_e       cls_o,
  output alu_e       alu_o
);

  always_comb begin
    cls_o = CLS_ILL;
    alu_o = ALU_ADD;
    case (op_i)
      OP_RTYPE: begin
        cls_o = CLS_R;
        case (funct_i)
          FN_ADD:  alu_o = ALU_ADD;
          FN_SUB:  alu_o = ALU_SUB;
          FN_AND:  alu_o = ALU_AND;
          FN_OR:   alu_o = ALU_OR;
          FN_SLT:  alu_o = ALU_SLT;
          default: cls_o = CLS_ILL;
        endcase
      end
      OP_LW:   cls_o = CLS_LW;
      OP_SW:   cls_o = CLS_SW;
      OP_BEQ:  begin cls_o = CLS_BEQ; alu_o = ALU_SUB; end
      OP_J:    cls_o = CLS_J;
      OP_ADDI: cls_o = CLS_ADDI;
      OP_ORI:  begin cls_o = CLS_ORI; alu_o = ALU_OR; end
      default: cls_o = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/mc_phase_ctrl.sv
// Multi-cycle MIPS control sequencer: per-phase datapath strobes, early skip,
// retired-instruction counter and sticky sequencing/illegal-opcode flags.
module mc_phase_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             nclr,
  input  logic [4:0]       p,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic [2:0]       alu_op,
  output logic             alu_src_imm,
  output logic             reg_dst_rd,
  output logic             mem_to_reg,
  output logic             mem_re,
  output logic             mem_we,
  output logic             reg_we,
  output logic             skip,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             ill_err,
  output logic             seq_err
);

  cls_e             class_q, class_d, dec_cls;
  alu_e             alu_ctl_q, alu_ctl_d, dec_alu;
  ph_e              last_ph_q, last_ph_d, ph;
  logic             last_skip_q, last_skip_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ill_q, ill_d, seq_q, seq_d;
  logic             legal, final_ph;

  mc_decode u_decode (
    .op_i    (op),
    .funct_i (funct),
    .cls_o   (dec_cls),
    .alu_o   (dec_alu)
  );

  // Non-one-hot and idle both collapse to PH_NONE; they are told apart by p==0.
  always_comb begin
    case (p)
      5'b00001: ph = PH_IF;
      5'b00010: ph = PH_ID;
      5'b00100: ph = PH_EX;
      5'b01000: ph = PH_MEM;
      5'b10000: ph = PH_WB;
      default:  ph = PH_NONE;
    endcase
  end

  always_comb begin
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_src      = PCSRC_SEQ;
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    reg_dst_rd  = 1'b0;
    mem_to_reg  = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    reg_we      = 1'b0;
    skip        = 1'b0;
    if (nclr) begin
      case (ph)
        PH_IF: begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
        PH_EX: begin
          alu_op      = alu_ctl_q;
          alu_src_imm = (class_q inside {CLS_LW, CLS_SW, CLS_ADDI, CLS_ORI});
          case (class_q)
            CLS_BEQ: begin
              alu_op = ALU_SUB;
              pc_we  = zero;
              pc_src = PCSRC_BR;
              skip   = 1'b1;
            end
            CLS_J: begin
              pc_we  = 1'b1;
              pc_src = PCSRC_JUMP;
              skip   = 1'b1;
            end
            CLS_ILL: skip = 1'b1;
            default: ;
          endcase
        end
        PH_MEM: begin
          mem_re = (class_q == CLS_LW);
          mem_we = (class_q == CLS_SW);
          skip   = (class_q == CLS_SW);
        end
        PH_WB: begin
          reg_we     = (class_q inside {CLS_R, CLS_LW, CLS_ADDI, CLS_ORI});
          reg_dst_rd = (class_q == CLS_R);
          mem_to_reg = (class_q == CLS_LW);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (ph)
      PH_IF:   legal = (last_ph_q == PH_NONE) || (last_ph_q == PH_WB) || last_skip_q;
      PH_ID:   legal = (last_ph_q == PH_IF);
      PH_EX:   legal = (last_ph_q == PH_ID);
      PH_MEM:  legal = (last_ph_q == PH_EX);
      PH_WB:   legal = (last_ph_q == PH_MEM);
      default: legal = (p == 5'b00000);
    endcase
    final_ph = ((ph == PH_EX)  && (class_q inside {CLS_BEQ, CLS_J})) ||
               ((ph == PH_MEM) && (class_q == CLS_SW)) ||
               ((ph == PH_WB)  && (class_q inside {CLS_R, CLS_LW, CLS_ADDI, CLS_ORI}));
    class_d     = (ph == PH_ID) ? dec_cls : class_q;
    alu_ctl_d   = (ph == PH_ID) ? dec_alu : alu_ctl_q;
    last_ph_d   = ph;
    last_skip_d = skip;
    cnt_d       = final_ph ? cnt_q + 1'b1 : cnt_q;
    ill_d       = ill_q | ((ph == PH_EX) && (class_q == CLS_ILL));
    seq_d       = seq_q | ~legal;
  end

  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      class_q     <= CLS_ILL;
      alu_ctl_q   <= ALU_ADD;
      last_ph_q   <= PH_NONE;
      last_skip_q <= 1'b0;
      cnt_q       <= '0;
      ill_q       <= 1'b0;
      seq_q       <= 1'b0;
    end else begin
      class_q     <= class_d;
      alu_ctl_q   <= alu_ctl_d;
      last_ph_q   <= last_ph_d;
      last_skip_q <= last_skip_d;
      cnt_q       <= cnt_d;
      ill_q       <= ill_d;
      seq_q       <= seq_d;
    end
  end

  assign retire_cnt = cnt_q;
  assign ill_err    = ill_q;
  assign seq_err    = seq_q;

endmodule
